cache_mem_arbiter: RTL



---
 rtl/cache_mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter: serialises icache reads and dcache reads/writes onto one RAM port with a watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the dcache has fixed priority.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wd_cnt;
  logic             d_req, granted, gnt_req, access;
  logic             complete, ram_err, wd_expire, pick_i;

  assign d_req     = dREN | dWEN;
  assign granted   = (state != IDLE);
  assign gnt_req   = (state == GNT_I) ? iREN : d_req;
  assign access    = (ramstate == RAM_ACCESS);
  assign complete  = granted & gnt_req & access;
  assign ram_err   = granted & gnt_req & (ramstate == RAM_ERROR);
  // ACCESS in the expiry cycle is a completion, so expiry requires a non-ACCESS cycle
  assign wd_expire = granted & gnt_req & ~access & (wd_cnt == WD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      last_gnt <= 1'b1;
    else if (complete)
      last_gnt <= (state == GNT_I);
  end

  assign pick_i = iREN & (~d_req | ~last_gnt);
`else
  assign pick_i = iREN & ~d_req;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!granted)
        wd_cnt <= '0;
      else if (!access)
        wd_cnt <= wd_cnt + 1'b1;
      if (ram_err || wd_expire)
        err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: begin
        if (pick_i)
          state_nxt = GNT_I;
        else if (d_req)
          state_nxt = GNT_D;
      end
      GNT_D: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramstore = dstore;
          if (access) begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end
      GNT_I: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (access) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Any grant ends after completion, abort, RAM error or watchdog expiry
    if (granted && (!gnt_req || access || ram_err || wd_expire))
      state_nxt = IDLE;
  end

endmodule
